// File: rtl/fifo_apb_requester.sv
// fifo_apb_requester: pops one command from the command FIFO, runs one APB transfer for it,
// and pushes one {slverr, rdata} response into the response FIFO.
module fifo_apb_requester #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_empty,
    input  logic [CMD_WIDTH-1:0]  cmd_data,
    output logic                  cmd_rd,
    input  logic                  rsp_full,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH:0]   rsp_data,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  cmd_rd_q, cmd_rd_d;
    logic                  rsp_wr_q, rsp_wr_d;
    logic [DATA_WIDTH:0]   rsp_data_q, rsp_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            cmd_rd_q   <= 1'b0;
            rsp_wr_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            cmd_rd_q   <= cmd_rd_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        cmd_rd_d   = 1'b0;
        rsp_wr_d   = 1'b0;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (!cmd_empty) begin
                    {pwrite_d, paddr_d, pwdata_d} = cmd_data;
                    cmd_rd_d = 1'b1;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready wins over the timeout on the final allowed cycle
                if (pready) begin
                    rsp_data_d = {pslverr, pwrite_q ? {DATA_WIDTH{1'b0}} : prdata};
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d = {1'b1, {DATA_WIDTH{1'b0}}};
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (!rsp_full) begin
                    rsp_wr_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign cmd_rd   = cmd_rd_q;
    assign rsp_wr   = rsp_wr_q;
    assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_fifo_apb_requester.sv
// tb_fifo_apb_requester: FIFO and APB slave models around fifo_apb_requester, with
// directed scenarios followed by randomized commands checked against a queue model.
module tb_fifo_apb_requester;
    localparam int TMO = 16;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
        int          wait_n;
    } cmd_t;

    logic        clk, rst, cmd_empty, cmd_rd, rsp_full, rsp_wr;
    logic [64:0] cmd_data;
    logic [32:0] rsp_data;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;

    cmd_t        cmdq[$];
    cmd_t        actq[$];
    logic [32:0] expq[$];
    int          pops[$];
    int          n_cmp, n_fail, cyc, acnt, n_rsp, last_len, full_mode;
    logic [32:0] last_rsp;

    fifo_apb_requester dut (
        .clk(clk), .rst(rst), .cmd_empty(cmd_empty), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
        .rsp_full(rsp_full), .rsp_wr(rsp_wr), .rsp_data(rsp_data),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input int wn, input logic err, input logic [31:0] rd);
        cmd_t c;
        c.w = w; c.a = a; c.d = d; c.wait_n = wn; c.err = err; c.rd = rd;
        return c;
    endfunction

    // One clock of FIFO/slave modelling; samples at the falling edge, drives for the next rising edge.
    task automatic tick();
        cmd_t c;
        logic rdy;
        @(negedge clk);
        cyc++;
        rdy = 1'b0;
        if (rsp_wr) begin
            chk("rsp_expected", 128'(expq.size() != 0), 128'(1));
            if (expq.size() != 0) chk("rsp_data", 128'(rsp_data), 128'(expq.pop_front()));
            last_rsp = rsp_data;
            n_rsp++;
        end
        if (cmd_rd) begin
            chk("pop_nonempty", 128'(cmdq.size() != 0), 128'(1));
            if (cmdq.size() != 0) begin
                c = cmdq.pop_front();
                chk("setup", 128'({psel, penable, pwrite, paddr, pwdata}), 128'({2'b10, c.w, c.a, c.d}));
                actq.push_back(c);
                pops.push_back(cyc);
            end
        end
        if (psel && penable) begin
            acnt++;
            chk("access_cmd", 128'(actq.size() != 0), 128'(1));
            if (actq.size() != 0) begin
                c = actq[0];
                chk("access_hold", 128'({pwrite, paddr, pwdata}), 128'({c.w, c.a, c.d}));
                rdy = (acnt == c.wait_n + 1);
            end
        end else if (acnt != 0) begin
            if (actq.size() != 0) begin
                c = actq.pop_front();
                chk("access_len", 128'(acnt), 128'((c.wait_n < TMO) ? c.wait_n + 1 : TMO));
                expq.push_back(c.wait_n >= TMO ? {1'b1, 32'h0} : {c.err, c.w ? 32'h0 : c.rd});
            end
            last_len = acnt;
            acnt = 0;
        end
        pready   = (psel && penable) ? rdy : 1'($urandom % 2);
        prdata   = rdy ? c.rd : $urandom;
        pslverr  = rdy ? c.err : 1'($urandom % 2);
        rsp_full = (full_mode == 0) ? ($urandom % 3 == 0) : (full_mode == 1);
        cmd_empty = (cmdq.size() == 0);
        cmd_data  = cmd_empty ? 65'h0 : {cmdq[0].w, cmdq[0].a, cmdq[0].d};
    endtask

    task automatic drain(input int lim);
        int g = 0;
        while ((cmdq.size() != 0 || actq.size() != 0 || expq.size() != 0 || acnt != 0) && g < lim) begin
            tick();
            g++;
        end
        chk("drain_in_time", 128'(g < lim), 128'(1));
    endtask

    initial begin
        int base, r0, g, r;
        n_cmp = 0; n_fail = 0; cyc = 0; acnt = 0; n_rsp = 0; last_len = 0; last_rsp = '0;
        full_mode = 2;
        rst = 1'b1; cmd_empty = 1'b1; cmd_data = '0; rsp_full = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", 128'({psel, penable, pwrite, paddr, pwdata, cmd_rd, rsp_wr, rsp_data}), 128'(0));
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_no_psel", 128'({psel, cmd_rd}), 128'(0));

        cmdq.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, $urandom));
        drain(100);
        chk("t1_rsp", 128'(last_rsp), 128'(0));
        chk("t1_len", 128'(last_len), 128'(1));

        cmdq.push_back(mk(1'b0, 32'h20, $urandom, 3, 1'b0, 32'h1234_5678));
        drain(100);
        chk("t2_rsp", 128'(last_rsp), 128'({1'b0, 32'h1234_5678}));
        chk("t2_len", 128'(last_len), 128'(4));

        cmdq.push_back(mk(1'b0, 32'h30, $urandom, 1, 1'b1, 32'hCAFE_0001));
        cmdq.push_back(mk(1'b0, 32'h34, $urandom, 0, 1'b0, 32'h55));
        drain(100);
        chk("t3_next_rsp", 128'(last_rsp), 128'({1'b0, 32'h55}));

        cmdq.push_back(mk(1'b0, 32'h40, $urandom, 40, 1'b0, $urandom));
        drain(200);
        chk("t4_rsp", 128'(last_rsp), 128'({1'b1, 32'h0}));
        chk("t4_len", 128'(last_len), 128'(TMO));

        cmdq.push_back(mk(1'b0, 32'h44, $urandom, 15, 1'b1, 32'h0BAD_F00D));
        drain(200);
        chk("t4_edge_rsp", 128'(last_rsp), 128'({1'b1, 32'h0BAD_F00D}));
        chk("t4_edge_len", 128'(last_len), 128'(TMO));

        base = pops.size();
        r0 = n_rsp;
        full_mode = 1;
        for (int i = 0; i < 4; i++) cmdq.push_back(mk(1'(i % 2), 32'h100 + 32'(4 * i), $urandom, 0, 1'b0, $urandom));
        repeat (14) tick();
        chk("t5_stall_pops", 128'(pops.size() - base), 128'(1));
        chk("t5_stall_rsp", 128'(n_rsp - r0), 128'(0));
        full_mode = 2;
        drain(200);
        chk("t5_rsp_count", 128'(n_rsp - r0), 128'(4));
        chk("t5_pop_count", 128'(pops.size() - base), 128'(4));
        if (pops.size() >= base + 4) begin
            chk("t5_gap_a", 128'(pops[base + 2] - pops[base + 1]), 128'(4));
            chk("t5_gap_b", 128'(pops[base + 3] - pops[base + 2]), 128'(4));
        end

        cmdq.push_back(mk(1'b0, 32'h200, $urandom, 40, 1'b0, $urandom));
        g = 0;
        while (!(psel && penable) && g < 20) begin
            tick();
            g++;
        end
        chk("t6_in_access", 128'(psel && penable), 128'(1));
        r0 = n_rsp;
        #2 rst = 1'b1;
        #1 chk("t6_async_clear", 128'({psel, penable, pwrite, paddr, pwdata, cmd_rd, rsp_wr, rsp_data}), 128'(0));
        actq.delete();
        expq.delete();
        acnt = 0;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("t6_no_stale_rsp", 128'(n_rsp - r0), 128'(0));
        chk("t6_idle", 128'({psel, penable, cmd_rd}), 128'(0));
        cmdq.push_back(mk(1'b0, 32'h204, $urandom, 2, 1'b0, 32'hA5A5_5A5A));
        drain(100);
        chk("t6_after_rsp", 128'(last_rsp), 128'({1'b0, 32'hA5A5_5A5A}));

        full_mode = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom % 10;
            cmdq.push_back(mk(1'($urandom % 2), $urandom & 32'hFFFF_FFFC, $urandom,
                              (r == 0) ? TMO + int'($urandom % 6) : int'($urandom % 4),
                              1'($urandom % 4 == 0), $urandom));
            repeat ($urandom % 4) tick();
        end
        drain(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
